// File: rtl/ber_prbs_chk_pkg.sv
// ber_pkg: shared PRBS-7 constants, counter widths, checker state encoding
// and a popcount helper for the BER checker and the BER pattern generator.
package ber_pkg;

  // PRBS-7, x^7 + x^6 + 1, Fibonacci form: new bit = s[6] ^ s[5] into s[0]
  localparam int PRBS7_ORDER = 7;
  localparam int PRBS7_TAP_A = 6;
  localparam int PRBS7_TAP_B = 5;

  localparam int BW_RECV_CNT = 58;
  localparam int BW_ERR_CNT  = 64;

  // widest supported data word; popcount is sized for it
  localparam int BW_DATA_MAX = 32;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    SYNC = 2'd1,
    LOCK = 2'd2
  } ber_state_e;

  // number of set bits in a (zero-extended) data word
  function automatic logic [5:0] popcount(input logic [BW_DATA_MAX-1:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < BW_DATA_MAX; i++) begin
      n = n + 6'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/ber_prbs_chk_if.sv
// ber_prbs_chk_if: data/result bundle between the deserialiser, the PRBS
// checker and the BER display.
//   DIN_VALID, DIN          : received word stream (DIN[BW_DATA-1] earliest bit)
//   LOCKED                  : checker is in lock
//   START                   : one-cycle pulse, RECV_CNT/ERR_CNT just updated
//   RECV_CNT, ERR_CNT       : window snapshots of the bit / error accumulators
//   LOL_CNT                 : loss-of-lock count, only with BER_LOL_CNT_EN
// modport master: stream source / result consumer; modport slave: checker.
interface ber_prbs_chk_if #(
  parameter int BW_DATA = 8
);
  import ber_pkg::*;

  logic                   DIN_VALID;
  logic [BW_DATA-1:0]     DIN;
  logic                   LOCKED;
  logic                   START;
  logic [BW_RECV_CNT-1:0] RECV_CNT;
  logic [BW_ERR_CNT-1:0]  ERR_CNT;

`ifdef BER_LOL_CNT_EN
  logic [15:0]            LOL_CNT;

  modport master (output DIN_VALID, DIN,
                  input  LOCKED, START, RECV_CNT, ERR_CNT, LOL_CNT);
  modport slave  (input  DIN_VALID, DIN,
                  output LOCKED, START, RECV_CNT, ERR_CNT, LOL_CNT);
`else
  modport master (output DIN_VALID, DIN,
                  input  LOCKED, START, RECV_CNT, ERR_CNT);
  modport slave  (input  DIN_VALID, DIN,
                  output LOCKED, START, RECV_CNT, ERR_CNT);
`endif

endinterface

// File: rtl/ber_prbs_chk_prbs7_step.sv
// prbs7_step: combinational PRBS-7 advance by BW_DATA bits.
//   state_in  [6:0]       : current register (s[6] is the oldest bit)
//   state_out [6:0]       : register after BW_DATA steps
//   word_out  [BW_DATA-1] : the BW_DATA generated bits, first bit in the MSB
// Shared with the BER pattern generator.
module prbs7_step
  import ber_pkg::*;
#(
  parameter int BW_DATA = 8
) (
  input  logic [PRBS7_ORDER-1:0] state_in,
  output logic [PRBS7_ORDER-1:0] state_out,
  output logic [BW_DATA-1:0]     word_out
);

  logic [PRBS7_ORDER-1:0] s_work;
  logic                   new_bit;

  always_comb begin
    s_work   = state_in;
    new_bit  = 1'b0;
    word_out = '0;
    for (int i = 0; i < BW_DATA; i++) begin
      new_bit                = s_work[PRBS7_TAP_A] ^ s_work[PRBS7_TAP_B];
      word_out[BW_DATA-1-i]  = new_bit;
      s_work                 = {s_work[PRBS7_ORDER-2:0], new_bit};
    end
    state_out = s_work;
  end

endmodule

// File: rtl/ber_prbs_chk.sv
// ber_prbs_chk: self-synchronising PRBS-7 checker feeding the BER display.
//   CLK, RST (sync, active-high), CLR (zero accumulators + window counter)
//   bus (ber_prbs_chk_if.slave): DIN_VALID/DIN in; LOCKED, START,
//   RECV_CNT, ERR_CNT (and LOL_CNT) out.
// Optional feature macro: BER_LOL_CNT_EN adds LOL_CNT, the saturating count
// of LOCK->HUNT transitions, snapshotted together with RECV_CNT/ERR_CNT.
// BW_DATA must be in 8..32 (seed uses DIN[6:0], popcount is 32 bits wide).
module ber_prbs_chk
  import ber_pkg::*;
#(
  parameter int BW_DATA    = 8,
  parameter int SYNC_WORDS = 4,
  parameter int LOL_WORDS  = 8,
  parameter int WIN_CYC    = 50000000
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          CLR,
  ber_prbs_chk_if.slave bus
);

  localparam int BW_SYNC = $clog2(SYNC_WORDS + 1);
  localparam int BW_BAD  = $clog2(LOL_WORDS + 1);
  localparam int BW_WIN  = $clog2(WIN_CYC + 1);

  localparam logic [1:0] ST_HUNT = HUNT;
  localparam logic [1:0] ST_SYNC = SYNC;
  localparam logic [1:0] ST_LOCK = LOCK;

  logic [1:0]             state_reg, state_next;
  logic [PRBS7_ORDER-1:0] pred_reg, pred_next, pred_adv;
  logic [BW_DATA-1:0]     pred_word, err_vec;
  logic [BW_SYNC-1:0]     sync_cnt_reg, sync_cnt_next;
  logic [BW_BAD-1:0]      bad_cnt_reg, bad_cnt_next;
  logic                   locked_reg;
  logic [5:0]             word_errs;
  logic                   bad_word;

  logic                   count_en;
  logic [BW_RECV_CNT:0]   recv_sum;
  logic [BW_ERR_CNT:0]    err_sum;
  logic [BW_RECV_CNT-1:0] recv_acc_reg, recv_next, recv_out_reg;
  logic [BW_ERR_CNT-1:0]  err_acc_reg, err_next, err_out_reg;
  logic [BW_WIN-1:0]      win_cnt_reg;
  logic                   win_tc;
  logic                   start_reg;

  prbs7_step #(.BW_DATA(BW_DATA)) u_step (
    .state_in  (pred_reg),
    .state_out (pred_adv),
    .word_out  (pred_word)
  );

  assign err_vec   = bus.DIN ^ pred_word;
  assign word_errs = popcount(BW_DATA_MAX'(err_vec));
  assign bad_word  = word_errs > 6'(BW_DATA / 4);

  // Lock state machine; only valid words move it. The predictor is loaded
  // from data only in HUNT and free-runs afterwards, so a single corrupted
  // bit never propagates into later predictions.
  always_comb begin
    state_next    = state_reg;
    pred_next     = pred_reg;
    sync_cnt_next = sync_cnt_reg;
    bad_cnt_next  = bad_cnt_reg;
    if (bus.DIN_VALID) begin
      case (state_reg)
        ST_HUNT: begin
          pred_next     = bus.DIN[PRBS7_ORDER-1:0];
          sync_cnt_next = '0;
          bad_cnt_next  = '0;
          state_next    = ST_SYNC;
        end
        ST_SYNC: begin
          pred_next = pred_adv;
          if (err_vec != '0) begin
            state_next = ST_HUNT;
          end else begin
            sync_cnt_next = sync_cnt_reg + 1'b1;
            if (sync_cnt_reg == BW_SYNC'(SYNC_WORDS - 1)) state_next = ST_LOCK;
          end
        end
        ST_LOCK: begin
          pred_next = pred_adv;
          if (bad_word) begin
            if (bad_cnt_reg == BW_BAD'(LOL_WORDS - 1)) begin
              bad_cnt_next = '0;
              state_next   = ST_HUNT;
            end else begin
              bad_cnt_next = bad_cnt_reg + 1'b1;
            end
          end else begin
            bad_cnt_next = '0;
          end
        end
        default: state_next = ST_HUNT;
      endcase
    end
  end

  // Counting happens only on locked valid words; a word arriving with CLR
  // is dropped so the cleared accumulators start from a clean zero.
  assign count_en  = bus.DIN_VALID && (state_reg == ST_LOCK) && !CLR;
  assign recv_sum  = {1'b0, recv_acc_reg} + (BW_RECV_CNT + 1)'(BW_DATA);
  assign err_sum   = {1'b0, err_acc_reg} + (BW_ERR_CNT + 1)'(word_errs);
  assign recv_next = !count_en ? recv_acc_reg :
                     recv_sum[BW_RECV_CNT] ? '1 : recv_sum[BW_RECV_CNT-1:0];
  assign err_next  = !count_en ? err_acc_reg :
                     err_sum[BW_ERR_CNT] ? '1 : err_sum[BW_ERR_CNT-1:0];
  assign win_tc    = (win_cnt_reg == BW_WIN'(WIN_CYC - 1));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg    <= ST_HUNT;
      pred_reg     <= '0;
      sync_cnt_reg <= '0;
      bad_cnt_reg  <= '0;
      locked_reg   <= 1'b0;
      recv_acc_reg <= '0;
      err_acc_reg  <= '0;
      win_cnt_reg  <= '0;
      start_reg    <= 1'b0;
      recv_out_reg <= '0;
      err_out_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      pred_reg     <= pred_next;
      sync_cnt_reg <= sync_cnt_next;
      bad_cnt_reg  <= bad_cnt_next;
      locked_reg   <= (state_next == ST_LOCK);
      recv_acc_reg <= CLR ? '0 : recv_next;
      err_acc_reg  <= CLR ? '0 : err_next;
      win_cnt_reg  <= (CLR || win_tc) ? '0 : win_cnt_reg + 1'b1;
      start_reg    <= win_tc;
      // snapshot includes this cycle's update, taken before any clear
      if (win_tc) begin
        recv_out_reg <= recv_next;
        err_out_reg  <= err_next;
      end
    end
  end

  assign bus.LOCKED   = locked_reg;
  assign bus.START    = start_reg;
  assign bus.RECV_CNT = recv_out_reg;
  assign bus.ERR_CNT  = err_out_reg;

`ifdef BER_LOL_CNT_EN
  logic        lol_event;
  logic [15:0] lol_acc_reg, lol_upd, lol_out_reg;

  assign lol_event = (state_reg == ST_LOCK) && (state_next == ST_HUNT);
  assign lol_upd   = (lol_event && lol_acc_reg != 16'hFFFF) ? lol_acc_reg + 16'd1
                                                            : lol_acc_reg;

  always_ff @(posedge CLK) begin
    if (RST) begin
      lol_acc_reg <= '0;
      lol_out_reg <= '0;
    end else begin
      lol_acc_reg <= CLR ? '0 : lol_upd;
      if (win_tc) lol_out_reg <= lol_upd;
    end
  end

  assign bus.LOL_CNT = lol_out_reg;
`endif

endmodule
